// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   op_e       - operation select encoding carried on the 'sub' input
//   slice_w    - bits handled by each pipeline stage
//   params_ok  - legality of a WIDTH/STAGES pair
//   full_add   - one full-adder cell, returns {carry_out, sum}
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/rca_slice.sv
// rca_slice
// Combinational ripple-carry slice of W full-adder cells.
// Ports:
//   a, b      in   W   slice operands (b already inverted for subtraction)
//   cin       in   1   carry into bit 0
//   s         out  W   slice sum
//   cout      out  1   carry out of the top cell
//   c_msb_in  out  1   carry into the top cell, used for signed overflow
module rca_slice
    import addsub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] carry;

    // The ripple is evaluated inside one process so the carry chain reads as
    // a sequence of cells rather than a self-referencing vector.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            {carry[i+1], s[i]} = full_add(a[i], b[i], carry[i]);
        end
    end

    assign cout     = carry[W];
    assign c_msb_in = carry[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// WIDTH-bit adder/subtractor split into STAGES ripple slices, one per clock.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake
//   a, b, sub, cin       operands; sub=1 gives a-b, otherwise a+b+cin
//   out_valid / out_ready result handshake
//   sum, cout, ovf       result, carry (no-borrow when subtracting), signed overflow
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S = slice_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : gParamCheck
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             stall;
    logic [WIDTH-1:0] bEff;
    logic             cinEff;

    // Per-stage slice wiring
    logic [S-1:0]     sliceA    [STAGES];
    logic [S-1:0]     sliceB    [STAGES];
    logic [S-1:0]     sliceS    [STAGES];
    logic             sliceCin  [STAGES];
    logic             sliceCout [STAGES];
    logic             sliceCmsb [STAGES];

    // Pipeline register k holds the state written by stage k
    logic             valid_d [STAGES];
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_d [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] opA_d   [STAGES];
    logic [WIDTH-1:0] opA_q   [STAGES];
    logic [WIDTH-1:0] opB_d   [STAGES];
    logic [WIDTH-1:0] opB_q   [STAGES];
    logic             ovf_d;
    logic             ovf_q;

    // A result that the consumer refuses freezes the whole pipe, bubbles included.
    assign stall    = valid_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Subtraction becomes a + ~b + 1, so only stage 0 ever knows about 'sub'.
    assign bEff   = (op_e'(sub) == OP_SUB) ? ~b : b;
    assign cinEff = (op_e'(sub) == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        rca_slice #(.W(S)) uSlice (
            .a        (sliceA[k]),
            .b        (sliceB[k]),
            .cin      (sliceCin[k]),
            .s        (sliceS[k]),
            .cout     (sliceCout[k]),
            .c_msb_in (sliceCmsb[k])
        );

        // Operands not yet consumed travel shifted down so every stage reads
        // its slice from bit 0; finished low sum bits accumulate in sum.
        if (k == 0) begin : gHead
            assign sliceA[k]   = a[S-1:0];
            assign sliceB[k]   = bEff[S-1:0];
            assign sliceCin[k] = cinEff;
            assign valid_d[k]  = in_valid;
            assign sum_d[k]    = WIDTH'(sliceS[k]);
            assign opA_d[k]    = a >> S;
            assign opB_d[k]    = bEff >> S;
        end else begin : gBody
            assign sliceA[k]   = opA_q[k-1][S-1:0];
            assign sliceB[k]   = opB_q[k-1][S-1:0];
            assign sliceCin[k] = carry_q[k-1];
            assign valid_d[k]  = valid_q[k-1];
            assign sum_d[k]    = sum_q[k-1] | (WIDTH'(sliceS[k]) << (k * S));
            assign opA_d[k]    = opA_q[k-1] >> S;
            assign opB_d[k]    = opB_q[k-1] >> S;
        end

        assign carry_d[k] = sliceCout[k];
    end

    // Overflow depends only on the two carries around the overall MSB cell,
    // which lives in the last slice.
    assign ovf_d = sliceCmsb[STAGES-1] ^ sliceCout[STAGES-1];

    // All stages advance together; data moves even for bubbles so the
    // only condition gating updates is the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                opA_q[k]   <= '0;
                opB_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                opA_q[k]   <= opA_d[k];
                opB_q[k]   <= opB_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
// Directed checks of the 16-bit, 4-stage configuration followed by an
// exhaustive 8-bit sweep run through three 8-bit instances at once.
module tb_pipelined_addsub;

    localparam int NVEC = 65536;

    logic        clk = 1'b0;
    logic        rstN;

    logic        inValid;
    logic        inReady;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        outValid;
    logic        outReady;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        in8Valid;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        sub8;
    logic        cin8;
    logic        out8Ready;
    logic        inReadyS1, inReadyS2, inReadyS8;
    logic        outValidS1, outValidS2, outValidS8;
    logic [7:0]  sumS1, sumS2, sumS8;
    logic        coutS1, coutS2, coutS8;
    logic        ovfS1, ovfS2, ovfS8;

    int          testsRun = 0;
    int          testsFailed = 0;

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(outValid), .out_ready(outReady),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dutS1 (
        .clk(clk), .rst_n(rstN), .in_valid(in8Valid), .in_ready(inReadyS1),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .out_valid(outValidS1), .out_ready(out8Ready),
        .sum(sumS1), .cout(coutS1), .ovf(ovfS1)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dutS2 (
        .clk(clk), .rst_n(rstN), .in_valid(in8Valid), .in_ready(inReadyS2),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .out_valid(outValidS2), .out_ready(out8Ready),
        .sum(sumS2), .cout(coutS2), .ovf(ovfS2)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(8)) dutS8 (
        .clk(clk), .rst_n(rstN), .in_valid(in8Valid), .in_ready(inReadyS8),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .out_valid(outValidS8), .out_ready(out8Ready),
        .sum(sumS8), .cout(coutS8), .ovf(ovfS8)
    );

    // Drives one operand set onto the 16-bit instance
    task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                                 input logic subIn, input logic cinIn, input logic validIn);
        a       = aIn;
        b       = bIn;
        sub     = subIn;
        cin     = cinIn;
        inValid = validIn;
    endtask

    // Reset values, then an asynchronous reset while items are in flight
    task automatic test_reset();
        rstN     = 1'b0;
        outReady = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b want 0", outValid); end
        testsRun++;
        if (sum !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_sum: got %h want 0000", sum); end
        testsRun++;
        if ({cout, ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
        rstN = 1'b1;
        @(negedge clk);
        testsRun++;
        if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0100 + 16'(i), 16'h0010, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        testsRun++;
        if ({outValid, sum} !== {1'b1, 16'h0111}) begin
            testsFailed++; $display("[TB] FAIL pre_flush_item: got valid=%b sum=%h want valid=1 sum=0111", outValid, sum);
        end

        rstN = 1'b0;
        #1;
        testsRun++;
        if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_out_valid: got %b want 0", outValid); end
        testsRun++;
        if (sum !== 16'h0000) begin testsFailed++; $display("[TB] FAIL flush_sum: got %h want 0000", sum); end
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            testsRun++;
            if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_no_emit cycle %0d: got %b want 0", i, outValid); end
        end
        testsRun++;
        if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_in_ready: got %b want 1", inReady); end
    endtask

    // Single items through an empty pipe: exact latency and carry/overflow corners
    task automatic test_add_sub();
        logic [15:0] tA [7];
        logic [15:0] tB [7];
        logic        tSub [7];
        logic        tCin [7];
        logic [15:0] eSum [7];
        logic        eCout [7];
        logic        eOvf [7];
        tA    = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0007, 16'h8000, 16'h1234, 16'hFFFF};
        tB    = '{16'h0001, 16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h4321, 16'hFFFF};
        tSub  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tCin  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eSum  = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0002, 16'h7FFF, 16'h5556, 16'hFFFF};
        eCout = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        eOvf  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        outReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tA[i], tB[i], tSub[i], tCin[i], 1'b1);
            @(posedge clk);
            @(negedge clk);
            inValid = 1'b0;
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
            end
            testsRun++;
            if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL latency_early vec %0d: got valid=%b want 0", i, outValid); end
            @(posedge clk);
            @(negedge clk);
            testsRun++;
            if (outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL latency_valid vec %0d: got %b want 1", i, outValid); end
            testsRun++;
            if (sum !== eSum[i]) begin testsFailed++; $display("[TB] FAIL addsub_sum vec %0d: got %h want %h", i, sum, eSum[i]); end
            testsRun++;
            if ({cout, ovf} !== {eCout[i], eOvf[i]}) begin
                testsFailed++; $display("[TB] FAIL addsub_flags vec %0d: got cout=%b ovf=%b want cout=%b ovf=%b", i, cout, ovf, eCout[i], eOvf[i]);
            end
        end
    endtask

    // Eight items on consecutive clocks must come out on eight consecutive clocks
    task automatic test_back_to_back();
        logic [15:0] tA [8];
        logic [15:0] tB [8];
        logic        tSub [8];
        logic        tCin [8];
        logic [17:0] eRes [8];
        int          k;
        tA   = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h8000, 16'h0010, 16'h0000, 16'h4000};
        tB   = '{16'h0001, 16'h0001, 16'h0000, 16'h0002, 16'h8000, 16'h0001, 16'h0001, 16'h4000};
        tSub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tCin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        eRes = '{{16'h0002, 2'b00}, {16'h0100, 2'b00}, {16'h1000, 2'b00}, {16'h0001, 2'b10},
                 {16'h0000, 2'b11}, {16'h000F, 2'b10}, {16'hFFFF, 2'b00}, {16'h8000, 2'b01}};
        outReady = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 8) applyStimulus(tA[cyc], tB[cyc], tSub[cyc], tCin[cyc], 1'b1);
            else         inValid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            k = cyc - 3;
            testsRun++;
            if (k >= 0 && k < 8) begin
                if ({outValid, sum, cout, ovf} !== {1'b1, eRes[k]}) begin
                    testsFailed++;
                    $display("[TB] FAIL stream item %0d: got valid=%b res=%h want valid=1 res=%h", k, outValid, {sum, cout, ovf}, eRes[k]);
                end
            end else if (outValid !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL stream_idle cycle %0d: got valid=%b want 0", cyc, outValid);
            end
        end
    endtask

    // Full pipe held by the consumer for five cycles, then drained
    task automatic test_stall();
        logic [15:0] tA [6];
        logic [15:0] tB [6];
        logic        tSub [6];
        logic        tCin [6];
        logic [17:0] eRes [6];
        tA   = '{16'h0011, 16'h0100, 16'h1000, 16'h7000, 16'h0003, 16'h00AB};
        tB   = '{16'h0022, 16'h0200, 16'hF000, 16'h1000, 16'h0004, 16'h0001};
        tSub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tCin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        eRes = '{{16'h0033, 2'b00}, {16'h0300, 2'b00}, {16'h0000, 2'b10},
                 {16'h8000, 2'b01}, {16'hFFFF, 2'b00}, {16'h00AD, 2'b00}};
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(tA[i], tB[i], tSub[i], tCin[i], 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        applyStimulus(tA[4], tB[4], tSub[4], tCin[4], 1'b1);
        for (int h = 0; h < 5; h++) begin
            testsRun++;
            if (inReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_in_ready cycle %0d: got %b want 0", h, inReady); end
            testsRun++;
            if ({outValid, sum, cout, ovf} !== {1'b1, eRes[0]}) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold cycle %0d: got valid=%b res=%h want valid=1 res=%h", h, outValid, {sum, cout, ovf}, eRes[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        outReady = 1'b1;
        #1;
        testsRun++;
        if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL release_in_ready: got %b want 1", inReady); end
        for (int r = 1; r <= 6; r++) begin
            @(posedge clk);
            @(negedge clk);
            testsRun++;
            if (r <= 5) begin
                if ({outValid, sum, cout, ovf} !== {1'b1, eRes[r]}) begin
                    testsFailed++;
                    $display("[TB] FAIL release item %0d: got valid=%b res=%h want valid=1 res=%h", r, outValid, {sum, cout, ovf}, eRes[r]);
                end
            end else if (outValid !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL release_extra: got valid=%b want 0", outValid);
            end
            if (r == 1) applyStimulus(tA[5], tB[5], tSub[5], tCin[5], 1'b1);
            if (r == 2) inValid = 1'b0;
        end
    endtask

    // Every 8-bit operand pair through STAGES = 1, 2 and 8 with random sub/cin
    task automatic test_exhaustive8();
        logic [9:0] q1 [$];
        logic [9:0] q2 [$];
        logic [9:0] q8 [$];
        logic [9:0] expR;
        logic [9:0] obsR;
        logic       obsV;
        logic       have;
        logic [8:0] full;
        logic [7:0] av, bv, es;
        logic       s, c, eo;
        out8Ready = 1'b1;
        for (int n = 0; n < NVEC + 32; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                have = 1'b0;
                expR = '0;
                case (d)
                    0: begin obsV = outValidS1; obsR = {sumS1, coutS1, ovfS1}; end
                    1: begin obsV = outValidS2; obsR = {sumS2, coutS2, ovfS2}; end
                    default: begin obsV = outValidS8; obsR = {sumS8, coutS8, ovfS8}; end
                endcase
                if (obsV === 1'b1) begin
                    case (d)
                        0: if (q1.size() != 0) begin have = 1'b1; expR = q1.pop_front(); end
                        1: if (q2.size() != 0) begin have = 1'b1; expR = q2.pop_front(); end
                        default: if (q8.size() != 0) begin have = 1'b1; expR = q8.pop_front(); end
                    endcase
                    testsRun++;
                    if (!have) begin
                        testsFailed++; $display("[TB] FAIL sweep_unexpected dut %0d: got res=%h with nothing outstanding", d, obsR);
                    end else if (obsR !== expR) begin
                        testsFailed++; $display("[TB] FAIL sweep dut %0d: got {sum,cout,ovf}=%h want %h", d, obsR, expR);
                    end
                end
            end
            if (n >= NVEC && q1.size() == 0 && q2.size() == 0 && q8.size() == 0) break;
            if (n < NVEC) begin
                av = 8'(n >> 8);
                bv = 8'(n);
                s  = 1'($urandom_range(0, 1));
                c  = 1'($urandom_range(0, 1));
                if (s) full = {1'b0, av} + {1'b0, ~bv} + 9'd1;
                else   full = {1'b0, av} + {1'b0, bv} + {8'd0, c};
                es = full[7:0];
                eo = s ? ((av[7] != bv[7]) && (es[7] != av[7])) : ((av[7] == bv[7]) && (es[7] != av[7]));
                q1.push_back({es, full[8], eo});
                q2.push_back({es, full[8], eo});
                q8.push_back({es, full[8], eo});
                a8 = av; b8 = bv; sub8 = s; cin8 = c; in8Valid = 1'b1;
            end else begin
                in8Valid = 1'b0;
            end
        end
        in8Valid = 1'b0;
        testsRun++;
        if (q1.size() + q2.size() + q8.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL sweep_drain: outstanding %0d/%0d/%0d want 0/0/0", q1.size(), q2.size(), q8.size());
        end
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        in8Valid  = 1'b0;
        a8        = '0;
        b8        = '0;
        sub8      = 1'b0;
        cin8      = 1'b0;
        out8Ready = 1'b1;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_stall();
        test_exhaustive8();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guards against a run that never reaches the summary
    initial begin
        #2000000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog");
    end

endmodule
